// File: rtl/sccb_target_regfile.sv
// sccb_target_regfile: SCCB target with a 256x8 register file, acking like an OV7670 so a master's init sequence can run without a sensor.
module sccb_target_regfile #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_RST     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  typedef enum logic [3:0] {IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_p_q, sda_p_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q, sub_q, wa_q, wd_q;
  logic [6:0] rd_q;
  logic oe_q, busy_q, wv_q, rw_q;
  logic [7:0] mem_q [256];
  logic scl, sda, rise, fall, start, stop, id_ok, shifting;
  logic [7:0] byte_in;
  assign scl      = scl_q[SYNC_STAGES-1];
  assign sda      = sda_q[SYNC_STAGES-1];
  assign rise     = scl & ~scl_p_q;
  assign fall     = ~scl & scl_p_q;
  assign start    = scl & scl_p_q & sda_p_q & ~sda;
  assign stop     = scl & scl_p_q & ~sda_p_q & sda;
  assign byte_in  = {sh_q[6:0], sda};
  assign id_ok    = sh_q[7:1] == DEVICE_ID[7:1];
  assign shifting = rise && cnt_q < 4'd8 && (state_q == ID || state_q == SUB || state_q == WDATA);
  assign siod_oe  = oe_q;
  assign wr_valid = wv_q;
  assign wr_addr  = wa_q;
  assign wr_data  = wd_q;
  assign busy     = busy_q;
  // Synchronizers idle high so leaving reset never fakes a START or STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q   <= '1;
      sda_q   <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= {scl_q[SYNC_STAGES-2:0], sioc};
      sda_q   <= {sda_q[SYNC_STAGES-2:0], siod_in};
      scl_p_q <= scl;
      sda_p_q <= sda;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      rd_q    <= 7'd0;
      sub_q   <= 8'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wv_q    <= 1'b0;
      wa_q    <= 8'd0;
      wd_q    <= 8'd0;
      rw_q    <= 1'b0;
      for (int i = 0; i < 256; i++) mem_q[i] <= REG_RST;
    end else begin
      wv_q <= 1'b0;
      if (start) begin
        state_q <= ID;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else if (stop) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (shifting) begin
        sh_q  <= byte_in;
        cnt_q <= cnt_q + 4'd1;
        if (state_q == SUB && cnt_q == 4'd7) sub_q <= byte_in;
        if (state_q == WDATA && cnt_q == 4'd7) begin
          mem_q[sub_q] <= byte_in;
          wv_q         <= 1'b1;
          wa_q         <= sub_q;
          wd_q         <= byte_in;
        end
      end else if (fall) begin
        case (state_q)
          ID: if (cnt_q == 4'd8) begin
            state_q <= id_ok ? ID_ACK : WAIT_STOP;
            oe_q    <= id_ok;
            rw_q    <= sh_q[0];
          end
          SUB, WDATA: if (cnt_q == 4'd8) begin
            state_q <= (state_q == SUB) ? SUB_ACK : WDATA_ACK;
            oe_q    <= 1'b1;
          end
          // The falling edge that ends the ID ack also presents read bit 7.
          ID_ACK: begin
            state_q <= rw_q ? RDATA : SUB;
            cnt_q   <= rw_q ? 4'd1 : 4'd0;
            oe_q    <= rw_q & ~mem_q[sub_q][7];
            rd_q    <= mem_q[sub_q][6:0];
          end
          SUB_ACK: begin
            state_q <= WDATA;
            cnt_q   <= 4'd0;
            oe_q    <= 1'b0;
          end
          WDATA_ACK: begin
            state_q <= WAIT_STOP;
            oe_q    <= 1'b0;
          end
          RDATA: if (cnt_q == 4'd8) begin
            state_q <= RD_NA;
            oe_q    <= 1'b0;
          end else begin
            oe_q  <= ~rd_q[6];
            rd_q  <= {rd_q[5:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
          end
          RD_NA: state_q <= WAIT_STOP;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sccb_target_regfile.sv
// tb_sccb_target_regfile: bit-banged SCCB master against a transaction-level model of the register file.
module tb_sccb_target_regfile;
  localparam int H = 8;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1;
  logic siod_in, siod_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  int n_chk = 0, n_fail = 0, n_wr = 0;
  logic [7:0] mem_m [256];
  logic [7:0] sub_m = 8'd0, last_wa = 8'd0, last_wd = 8'd0;
  logic [15:0] exp_q [$];
  logic [15:0] e;
  logic forbid = 1'b0;

  assign siod_in = sda & ~siod_oe;
  always #5 clk = ~clk;

  sccb_target_regfile dut (
    .clk(clk), .rst(rst), .sioc(scl), .siod_in(siod_in), .siod_oe(siod_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e[15:8]);
        chk("wr_data", wr_data, e[7:0]);
      end
      n_wr++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (forbid) chk("no_pull", siod_oe, 0);
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic s_start();
    sda = 1'b1; w(H); scl = 1'b1; w(H); sda = 1'b0; w(H); scl = 1'b0; w(2);
  endtask

  task automatic s_stop();
    sda = 1'b0; w(H); scl = 1'b1; w(H); sda = 1'b1; w(H);
  endtask

  task automatic s_bit(input logic b, output logic r);
    sda = b; w(H); scl = 1'b1; w(H/2); r = siod_in; w(H/2); scl = 1'b0; w(2);
  endtask

  task automatic xbyte(input logic [7:0] d, output logic [7:0] r, output logic a);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      s_bit(d[i], b);
      r[i] = b;
    end
    s_bit(1'b1, a);
  endtask

  task automatic send_id_sub(input logic [7:0] id, input logic [7:0] sub, input logic ok);
    logic [7:0] r;
    logic a;
    xbyte(id, r, a);
    chk("id_ack", a, !ok);
    chk("id_echo", r, id);
    xbyte(sub, r, a);
    chk("sub_ack", a, !ok);
    chk("sub_echo", r, sub);
    if (ok) sub_m = sub;
  endtask

  task automatic op_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data);
    logic [7:0] r;
    logic a, ok;
    ok = id[7:1] == 7'h21;
    forbid = !ok;
    s_start();
    chk("busy_start", busy, 1);
    send_id_sub(id, sub, ok);
    if (ok) begin
      exp_q.push_back({sub, data});
      mem_m[sub] = data;
    end
    xbyte(data, r, a);
    chk("data_ack", a, !ok);
    chk("data_echo", r, data);
    s_stop();
    forbid = 1'b0;
    chk("busy_stop", busy, 0);
  endtask

  task automatic op_sub2(input logic [7:0] sub);
    s_start();
    send_id_sub(8'h42, sub, 1'b1);
    s_stop();
  endtask

  task automatic op_read(input logic [7:0] id, output logic [7:0] r);
    logic a, ok;
    logic [7:0] ri;
    ok = id[7:1] == 7'h21;
    forbid = !ok;
    s_start();
    xbyte(id, ri, a);
    chk("rid_ack", a, !ok);
    xbyte(8'hFF, r, a);
    chk("rd_data", r, ok ? mem_m[sub_m] : 8'hFF);
    chk("rd_na_released", a, 1);
    s_stop();
    forbid = 1'b0;
    chk("busy_rd_stop", busy, 0);
  endtask

  task automatic op_partial(input logic [7:0] sub, input logic [7:0] data, input int nb);
    logic b;
    s_start();
    send_id_sub(8'h42, sub, 1'b1);
    for (int i = 7; i > 7 - nb; i--) s_bit(data[i], b);
    s_stop();
  endtask

  initial begin
    logic [7:0] r, id, sub, dat;
    logic b;
    int nw0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    w(5);
    chk("rst_oe", siod_oe, 0);
    chk("rst_wv", wr_valid, 0);
    chk("rst_wa", wr_addr, 0);
    chk("rst_wd", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    w(5);
    // write 0x80 to 0x12
    op_write(8'h42, 8'h12, 8'h80);
    chk("t1_count", n_wr, 1);
    chk("t1_addr", last_wa, 8'h12);
    chk("t1_data", last_wd, 8'h80);
    // read it back, then an untouched register
    nw0 = n_wr;
    op_sub2(8'h12);
    op_read(8'h43, r);
    chk("t2_read", r, 8'h80);
    chk("t2_no_wr", n_wr, nw0);
    op_sub2(8'h3A);
    op_read(8'h43, r);
    chk("t2_unread", r, 8'h00);
    // foreign device address
    nw0 = n_wr;
    op_write(8'h60, 8'h12, 8'h55);
    chk("t3_no_wr", n_wr, nw0);
    // truncated data byte
    op_partial(8'h40, 8'hFF, 4);
    op_read(8'h43, r);
    chk("t4_read", r, 8'h00);
    chk("t4_no_wr", n_wr, nw0);
    // repeated start after the sub-address ack
    s_start();
    send_id_sub(8'h42, 8'h77, 1'b1);
    op_write(8'h42, 8'h15, 8'hA5);
    chk("t5_count", n_wr, nw0 + 1);
    chk("t5_addr", last_wa, 8'h15);
    chk("t5_data", last_wd, 8'hA5);
    // reset while acknowledging the ID
    s_start();
    for (int i = 7; i >= 0; i--) s_bit(id_bit(i), b);
    w(4);
    chk("t6_oe_ack", siod_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe_rst", siod_oe, 0);
    chk("t6_busy_rst", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    sub_m = 8'h00;
    w(5);
    op_read(8'h43, r);
    chk("t6_read_rst", r, 8'h00);
    op_write(8'h42, 8'h15, 8'h3C);
    op_read(8'h43, r);
    chk("t6_read_after", r, 8'h3C);
    // random mix
    for (int k = 0; k < 30; k++) begin
      sub = 8'($urandom_range(0, 7));
      dat = 8'($urandom);
      id = 8'($urandom);
      if (id[7:1] == 7'h21) id = id ^ 8'h80;
      case ($urandom_range(0, 4))
        0, 1: op_write(8'h42, sub, dat);
        2: begin
          op_sub2(sub);
          op_read(8'h43, r);
        end
        3: op_write({id[7:1], 1'b0}, sub, dat);
        default: op_read({id[7:1], 1'b1}, r);
      endcase
    end
    w(10);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic id_bit(input int i);
    logic [7:0] v;
    v = 8'h42;
    return v[i];
  endfunction
endmodule
